// File: rtl/seq_det_word_ctrl.sv
// Word-to-serial sequencer for an external Moore 1011 detector.
// Scans each accepted word MSB-first and returns per-word hit count and hit mask.
//   state | meaning
//   IDLE  | waiting for a word, s_ready high
//   CLR   | one-cycle detector reset before scanning
//   SHIFT | presenting word bits on det_din, MSB first
//   DRAIN | zero fill while the last bits' detector results arrive
//   DONE  | result presented, waiting for m_ready
module seq_det_word_ctrl #(
    parameter  int WIDTH   = 8,
    parameter  int DET_LAT = 2,
    localparam int CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_clr,
    output logic             det_din,
    output logic             det_rst_n,
    input  logic             det_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [CNT_W-1:0] m_count,
    output logic [WIDTH-1:0] m_hit_mask,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLR   = 3'd1;
    localparam logic [2:0] SHIFT = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_mask;
    logic [IDX_W-1:0] r_tag     [DET_LAT];
    logic [DET_LAT-1:0] r_tag_vld;

    logic [IDX_W-1:0] w_bit_idx;
    logic             w_hit;

    assign w_bit_idx = IDX_W'(WIDTH - 1) - r_bit_cnt[IDX_W-1:0];
    // Tag tail lines up with det_dout for the bit presented DET_LAT edges earlier
    assign w_hit = ((r_state == SHIFT) || (r_state == DRAIN)) &&
                   r_tag_vld[DET_LAT-1] && det_dout;

    assign s_ready    = reset & (r_state == IDLE);
    assign det_rst_n  = reset & (r_state != CLR);
    assign det_din    = (r_state == SHIFT) & r_shreg[WIDTH-1];
    assign m_valid    = (r_state == DONE);
    assign m_count    = r_count;
    assign m_hit_mask = r_mask;
    assign busy       = (r_state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag_vld <= '0;
            for (int i = 0; i < DET_LAT; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_tag[0]     <= w_bit_idx;
            r_tag_vld[0] <= (r_state == SHIFT);
            for (int i = 1; i < DET_LAT; i++) begin
                r_tag[i]     <= r_tag[i-1];
                r_tag_vld[i] <= r_tag_vld[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_count   <= '0;
            r_mask    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_shreg   <= s_data;
                        r_count   <= '0;
                        r_mask    <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= s_clr ? CLR : SHIFT;
                    end
                end
                CLR: r_state <= SHIFT;
                SHIFT: begin
                    r_shreg <= r_shreg << 1;
                    if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                        r_bit_cnt <= '0;
                        r_state   <= DRAIN;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (r_bit_cnt == CNT_W'(DET_LAT - 1)) begin
                        r_bit_cnt <= '0;
                        r_state   <= DONE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (w_hit) begin
                r_mask[r_tag[DET_LAT-1]] <= 1'b1;
                r_count                  <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_det_word_ctrl.sv
// Bench for seq_det_word_ctrl with a behavioural Moore 1011 detector attached.
// Stimulus pushes expected results; a negedge monitor pops and compares on each handshake.
module tb_seq_det_word_ctrl;

    localparam int W   = 8;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [W-1:0] s_data = '0;
    logic         s_clr = 1'b0;
    logic         det_din;
    logic         det_rst_n;
    logic         det_dout;
    logic         m_valid;
    logic         m_ready = 1'b1;
    logic [3:0]   m_count;
    logic [W-1:0] m_hit_mask;
    logic         busy;

    seq_det_word_ctrl #(.WIDTH(W), .DET_LAT(LAT)) dut (
        .clock(clk), .reset(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_clr(s_clr),
        .det_din(det_din), .det_rst_n(det_rst_n), .det_dout(det_dout),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count),
        .m_hit_mask(m_hit_mask), .busy(busy)
    );

    always #5 clk = ~clk;

    // Moore 1011 detector with overlap: S0 none, S1 "1", S2 "10", S3 "101", S4 "1011"
    logic [2:0] ds;
    always @(posedge clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            ds       <= 3'd0;
            det_dout <= 1'b0;
        end else begin
            case (ds)
                3'd0: ds <= det_din ? 3'd1 : 3'd0;
                3'd1: ds <= det_din ? 3'd1 : 3'd2;
                3'd2: ds <= det_din ? 3'd3 : 3'd0;
                3'd3: ds <= det_din ? 3'd4 : 3'd2;
                default: ds <= det_din ? 3'd1 : 3'd2;
            endcase
            det_dout <= (ds == 3'd4);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]   cnt;
        logic [W-1:0] mask;
        int           acc;
        int           lat;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_pass = 0;
    int n_total = 0;
    int last_hs = -1;
    int rst_pulses = 0;
    logic mv_q = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            mv_q = 1'b0;
        end else begin
            if (!det_rst_n) rst_pulses++;
            if (m_valid && !mv_q) begin
                check("result_pending", int'(sb.size() > 0), 1);
                if (sb.size() > 0) check("valid_latency", cyc - sb[0].acc, sb[0].lat);
            end
            if (m_valid && m_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("m_count", int'(m_count), int'(e.cnt));
                check("m_hit_mask", int'(m_hit_mask), int'(e.mask));
                last_hs = cyc + 1;
            end
            mv_q = m_valid;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic clr, input logic [3:0] ec,
                        input logic [W-1:0] em, input bit push, input bit hold,
                        output int acc);
        int n = 0;
        s_data  = d;
        s_clr   = clr;
        s_valid = 1'b1;
        #1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            check("accept_timeout", 0, 1);
            s_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (push) sb.push_back('{ec, em, acc, W + LAT + int'(clr)});
        @(posedge clk);
        #1;
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", int'(sb.size() == 0 && !busy), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, hs1, nv;
        repeat (2) @(negedge clk);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_det_din", int'(det_din), 0);
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_det_rst_n", int'(det_rst_n), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", int'(s_ready), 1);

        send(8'b1011_0000, 1'b1, 4'd1, 8'h10, 1, 0, a1); wait_idle();
        send(8'b1011_0110, 1'b1, 4'd2, 8'h12, 1, 0, a1); wait_idle();
        send(8'b1001_1110, 1'b1, 4'd0, 8'h00, 1, 0, a1); wait_idle();
        // detector has settled to S0 via zero fill, so no clear is needed here
        send(8'b1011_0000, 1'b0, 4'd1, 8'h10, 1, 0, a1); wait_idle();
        send(8'b0000_1011, 1'b1, 4'd1, 8'h01, 1, 0, a1); wait_idle();

        // result held while consumer stalls
        @(posedge clk); #1 m_ready = 1'b0;
        send(8'b1011_0110, 1'b1, 4'd2, 8'h12, 1, 0, a1);
        nv = 0;
        while (!m_valid && nv < 50) begin @(negedge clk); nv++; end
        check("stall_valid_seen", int'(m_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_m_valid", int'(m_valid), 1);
            check("stall_m_count", int'(m_count), 2);
            check("stall_m_hit_mask", int'(m_hit_mask), 8'h12);
            check("stall_s_ready", int'(s_ready), 0);
            check("stall_busy", int'(busy), 1);
        end
        @(posedge clk); #1 m_ready = 1'b1;
        @(posedge clk); #1;
        check("release_s_ready", int'(s_ready), 1);
        check("release_busy", int'(busy), 0);
        wait_idle();

        // reset while data bit 3 is on det_din
        send(8'b1011_0000, 1'b1, 4'd0, 8'h00, 0, 0, a1);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_m_valid", int'(m_valid), 0);
        check("midrst_det_rst_n", int'(det_rst_n), 0);
        check("midrst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("midrst_s_ready", int'(s_ready), 1);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_valid) nv++;
        end
        check("midrst_no_valid", nv, 0);
        send(8'b1011_0000, 1'b1, 4'd1, 8'h10, 1, 0, a1); wait_idle();

        // back-to-back words with s_valid held high
        rst_pulses = 0;
        send(8'b1011_0000, 1'b1, 4'd1, 8'h10, 1, 1, a1);
        send(8'b1011_0110, 1'b1, 4'd2, 8'h12, 1, 0, a2);
        hs1 = last_hs;
        check("b2b_accept_cycle", a2, hs1 + 1);
        wait_idle();
        check("b2b_det_rst_pulses", rst_pulses, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
